// File: rtl/vend_pkg.sv
// vend_pkg: coin codes and dispenser state encoding shared by the vend/payout blocks
package vend_pkg;
  typedef enum logic [1:0] {COIN_0 = 2'b00, COIN_5 = 2'b01, COIN_10 = 2'b10} coin_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_PULSE, ST_WAIT, ST_DONE} disp_state_t;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, hopper and status signals of the coin payout engine
interface change_dispenser_if #(
  parameter int AMT_W = 4,
  parameter int INV_W = 8
);
  logic req;
  logic [AMT_W-1:0] amount;
  logic drop_sense;
  logic refill;
  logic [1:0] eject;
  logic busy;
  logic done;
  logic fault;
  logic [AMT_W-1:0] shortfall;
  logic [INV_W-1:0] inv5;
  logic [INV_W-1:0] inv10;
  modport master (
    output req, amount, drop_sense, refill,
    input eject, busy, done, fault, shortfall, inv5, inv10
  );
  modport slave (
    input req, amount, drop_sense, refill,
    output eject, busy, done, fault, shortfall, inv5, inv10
  );
endinterface

// File: rtl/dispense_timer.sv
// dispense_timer: loadable down-counter timing both solenoid pulses and drop timeouts
module dispense_timer #(
  parameter int W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic [W-1:0] load_val,
  output logic expired
);
  logic [W-1:0] cnt;
  // load a fresh interval, otherwise count down and rest at zero
  always_ff @(posedge clock)
    cnt <= reset ? '0 : load ? load_val : cnt - W'(cnt != '0);
  assign expired = cnt == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out requested change as 5c/10c coins through hopper solenoids
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int INV_W       = 8,
  parameter int INV5_INIT   = 20,
  parameter int INV10_INIT  = 10,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clock,
  input logic reset,
  change_dispenser_if.slave bus
);
  localparam int TW = $clog2((PULSE_CYC > TIMEOUT_CYC ? PULSE_CYC : TIMEOUT_CYC) + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT_CYC - 1);
  disp_state_t state, state_n;
  coin_t coin, coin_n;
  logic [AMT_W-1:0] rem, rem_n, short_q, short_n;
  logic [INV_W-1:0] inv5, inv5_n, inv10, inv10_n;
  logic [1:0] eject, eject_n;
  logic busy, busy_n, done, done_n, fault, fault_n, seen, seen_n;
  logic t_load, t_exp, drop;
  logic [TW-1:0] t_val;
  // a drop noticed during the pulse is remembered so it counts exactly once in WAIT
  assign drop = seen | bus.drop_sense;
  dispense_timer #(.W(TW)) u_timer (
    .clock(clock),
    .reset(reset),
    .load(t_load),
    .load_val(t_val),
    .expired(t_exp)
  );
  // state and every output are registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      coin <= COIN_0;
      rem <= '0;
      short_q <= '0;
      inv5 <= INV_W'(INV5_INIT);
      inv10 <= INV_W'(INV10_INIT);
      eject <= COIN_0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      seen <= 1'b0;
    end else begin
      state <= state_n;
      coin <= coin_n;
      rem <= rem_n;
      short_q <= short_n;
      inv5 <= inv5_n;
      inv10 <= inv10_n;
      eject <= eject_n;
      busy <= busy_n;
      done <= done_n;
      fault <= fault_n;
      seen <= seen_n;
    end
  end
  // next state: greedy 10c-first coin choice that never overpays or underflows a hopper
  always_comb begin
    state_n = state;
    coin_n = coin;
    rem_n = rem;
    short_n = short_q;
    inv5_n = inv5;
    inv10_n = inv10;
    eject_n = COIN_0;
    busy_n = busy;
    done_n = 1'b0;
    fault_n = 1'b0;
    seen_n = seen;
    t_load = 1'b0;
    t_val = PULSE_LOAD;
    case (state)
      ST_IDLE: begin
        if (bus.refill) begin
          inv5_n = INV_W'(INV5_INIT);
          inv10_n = INV_W'(INV10_INIT);
        end
        if (bus.req) begin
          rem_n = bus.amount;
          busy_n = 1'b1;
          state_n = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem == '0) begin
          done_n = 1'b1;
          short_n = '0;
          state_n = ST_DONE;
        end else if ((rem >= AMT_W'(2) && inv10 != '0) || inv5 != '0) begin
          coin_n = (rem >= AMT_W'(2) && inv10 != '0) ? COIN_10 : COIN_5;
          eject_n = (rem >= AMT_W'(2) && inv10 != '0) ? COIN_10 : COIN_5;
          seen_n = 1'b0;
          t_load = 1'b1;
          state_n = ST_PULSE;
        end else begin
          done_n = 1'b1;
          fault_n = 1'b1;
          short_n = rem;
          state_n = ST_DONE;
        end
      end
      ST_PULSE: begin
        seen_n = drop;
        eject_n = t_exp ? COIN_0 : coin;
        t_load = t_exp;
        t_val = WAIT_LOAD;
        state_n = t_exp ? ST_WAIT : ST_PULSE;
      end
      ST_WAIT: begin
        if (drop) begin
          inv10_n = coin == COIN_10 ? inv10 - INV_W'(1) : inv10;
          inv5_n = coin == COIN_10 ? inv5 : inv5 - INV_W'(1);
          rem_n = rem - (coin == COIN_10 ? AMT_W'(2) : AMT_W'(1));
          seen_n = 1'b0;
          state_n = ST_SELECT;
        end else if (t_exp) begin
          done_n = 1'b1;
          fault_n = 1'b1;
          short_n = rem;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_n = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  assign bus.eject = eject;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.fault = fault;
  assign bus.shortfall = short_q;
  assign bus.inv5 = inv5;
  assign bus.inv10 = inv10;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payout scenarios checked against a transaction-level model
module tb_change_dispenser;
  import vend_pkg::*;
  localparam int AMT_W = 4, INV_W = 8, INV5_INIT = 20, INV10_INIT = 10;
  localparam int PULSE_CYC = 4, TIMEOUT_CYC = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  change_dispenser_if #(.AMT_W(AMT_W), .INV_W(INV_W)) bus ();
  change_dispenser #(
    .AMT_W(AMT_W), .INV_W(INV_W), .INV5_INIT(INV5_INIT), .INV10_INIT(INV10_INIT),
    .PULSE_CYC(PULSE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  int m_inv5 = INV5_INIT;
  int m_inv10 = INV10_INIT;
  logic [1:0] exp_coins[$];
  bit exp_fault = 1'b0;
  bit exp_pending = 1'b0;
  bit chk_en = 1'b0;
  int exp_short = 0;
  int r_mode = 0;
  int r_jam = -1;
  int pidx = 0;
  int lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // transaction model: which coins get paid, final hoppers, fault and shortfall
  task automatic predict(input int amt, input int jam_at);
    int rem = amt;
    int k = 0;
    logic [1:0] c;
    exp_fault = 1'b0;
    exp_short = 0;
    exp_coins.delete();
    while (rem > 0) begin
      if (rem >= 2 && m_inv10 > 0) c = COIN_10;
      else if (m_inv5 > 0) c = COIN_5;
      else begin
        exp_fault = 1'b1;
        exp_short = rem;
        break;
      end
      exp_coins.push_back(c);
      if (k == jam_at) begin
        exp_fault = 1'b1;
        exp_short = rem;
        break;
      end
      if (c == COIN_10) begin
        m_inv10--;
        rem -= 2;
      end else begin
        m_inv5--;
        rem -= 1;
      end
      k++;
    end
    exp_pending = 1'b1;
  endtask

  // hopper sensor: mode 0 drops in the first WAIT cycle, mode 1 mid-pulse; the jammed coin never drops
  initial begin
    logic [1:0] prev_ej = 2'b00;
    int pcyc = 0;
    bus.drop_sense = 1'b0;
    forever begin
      @(negedge clock);
      bus.drop_sense = 1'b0;
      if (bus.eject != 2'b00) begin
        pcyc = (prev_ej == 2'b00) ? 0 : pcyc + 1;
        if (r_mode == 1 && pcyc == 1 && pidx != r_jam) bus.drop_sense = 1'b1;
      end else if (prev_ej != 2'b00) begin
        if (r_mode == 0 && pidx != r_jam) bus.drop_sense = 1'b1;
        pidx++;
      end
      prev_ej = bus.eject;
    end
  end

  // compare process: pulse codes and widths every cycle, completion status against the model
  initial begin
    int run_len = 0;
    logic [1:0] run_coin = 2'b00;
    forever begin
      @(negedge clock);
      if (!chk_en) run_len = 0;
      else begin
        check("eject_never_11", {31'd0, bus.eject == 2'b11}, 0);
        check("fault_only_with_done", {31'd0, bus.fault & ~bus.done}, 0);
        if (bus.eject != 2'b00) begin
          if (run_len > 0) check("eject_stable", bus.eject, run_coin);
          run_coin = bus.eject;
          run_len++;
        end else if (run_len > 0) begin
          check("pulse_width", run_len, PULSE_CYC);
          check("coin_sequence", run_coin, exp_coins.size() > 0 ? exp_coins.pop_front() : 2'b11);
          run_len = 0;
        end
        if (bus.done) begin
          check("done_expected", exp_pending, 1);
          check("fault", bus.fault, exp_fault);
          check("shortfall", bus.shortfall, exp_short);
          check("inv5", bus.inv5, m_inv5);
          check("inv10", bus.inv10, m_inv10);
          check("coins_left", exp_coins.size(), 0);
          exp_pending = 1'b0;
        end
      end
    end
  end

  task automatic run_txn(input int amt, input int jam_at, input int mode, input bit poke, output int n);
    predict(amt, jam_at);
    r_mode = mode;
    r_jam = jam_at;
    pidx = 0;
    bus.req = 1'b1;
    bus.amount = AMT_W'(amt);
    @(negedge clock);
    bus.req = 1'b0;
    n = 1;
    check("busy_after_accept", bus.busy, 1);
    while (!bus.done && n < 300) begin
      @(negedge clock);
      n++;
      bus.req = poke && n == 3;
      bus.refill = poke && n == 3;
      bus.amount = poke && n == 3 ? 4'd15 : AMT_W'(amt);
    end
    bus.req = 1'b0;
    bus.refill = 1'b0;
    check("done_seen", bus.done, 1);
    @(negedge clock);
    check("busy_cleared", bus.busy, 0);
    if (poke) begin
      repeat (3) @(negedge clock);
      check("busy_req_ignored", bus.busy, 0);
    end
  endtask

  task automatic do_refill();
    bus.refill = 1'b1;
    @(negedge clock);
    bus.refill = 1'b0;
    m_inv5 = INV5_INIT;
    m_inv10 = INV10_INIT;
    check("refill_inv5", bus.inv5, 20);
    check("refill_inv10", bus.inv10, 10);
  endtask

  initial begin
    bus.req = 1'b0;
    bus.amount = '0;
    bus.refill = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_eject", bus.eject, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_shortfall", bus.shortfall, 0);
    check("rst_inv5", bus.inv5, 20);
    check("rst_inv10", bus.inv10, 10);
    reset = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    run_txn(3, -1, 0, 0, lat);
    check("t3_latency", lat, 14);
    check("t3_inv10", bus.inv10, 9);
    check("t3_inv5", bus.inv5, 19);
    run_txn(2, -1, 0, 0, lat);
    check("one_coin_latency", lat, 4 + PULSE_CYC);
    run_txn(15, -1, 0, 0, lat);
    check("t15_latency", lat, 50);
    check("t15_inv10", bus.inv10, 1);
    check("t15_inv5", bus.inv5, 18);
    run_txn(2, -1, 0, 0, lat);
    check("drained_inv10", bus.inv10, 0);
    run_txn(4, -1, 0, 1, lat);
    check("t4_latency", lat, 26);
    check("t4_inv5", bus.inv5, 14);
    check("t4_inv10", bus.inv10, 0);
    do_refill();
    for (int i = 0; i < 20; i++) run_txn(1, -1, 1, 0, lat);
    check("empty5_inv5", bus.inv5, 0);
    check("empty5_inv10", bus.inv10, 10);
    run_txn(1, -1, 0, 0, lat);
    check("no5_latency", lat, 2);
    check("no5_shortfall", bus.shortfall, 1);
    check("no5_inv10", bus.inv10, 10);
    run_txn(3, -1, 0, 0, lat);
    check("no_overpay_shortfall", bus.shortfall, 1);
    check("no_overpay_inv10", bus.inv10, 9);
    do_refill();
    run_txn(2, 0, 0, 0, lat);
    check("jam_latency", lat, 2 + PULSE_CYC + TIMEOUT_CYC);
    check("jam_shortfall", bus.shortfall, 2);
    check("jam_inv10", bus.inv10, 10);
    run_txn(0, -1, 0, 0, lat);
    check("zero_latency", lat, 2);
    check("zero_shortfall", bus.shortfall, 0);
    chk_en = 1'b0;
    r_mode = 0;
    r_jam = -1;
    pidx = 0;
    bus.req = 1'b1;
    bus.amount = 4'd2;
    @(negedge clock);
    bus.req = 1'b0;
    for (int i = 0; i < 10 && bus.eject == 2'b00; i++) @(negedge clock);
    check("pulse_before_reset", bus.eject, COIN_10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_eject", bus.eject, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_inv5", bus.inv5, 20);
    check("abort_inv10", bus.inv10, 10);
    exp_coins.delete();
    exp_pending = 1'b0;
    m_inv5 = INV5_INIT;
    m_inv10 = INV10_INIT;
    @(negedge clock);
    chk_en = 1'b1;
    run_txn(3, -1, 0, 0, lat);
    check("recover_latency", lat, 14);
    check("recover_inv5", bus.inv5, 19);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
